ahbl_master_arbiter: RTL and testbench

Two-port AHB-Lite master arbiter. It shares one AHB-Lite master port (M_) between two upstream AHB-Lite masters, typically the CPU on S0 and the DMA controller master port on S1. Each upstream address phase is captured in a per-port pending register, then replayed on the shared bus under fixed-priority or round-robin arbitration. The upstream master is held in its data phase until the shared bus completes it. One outstanding transfer per port; single transfers only.

---
 rtl/ahbl_master_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ahbl_master_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_master_arbiter.sv
// Two-port AHB-Lite master arbiter: captures each upstream address phase,
// replays it on one shared master port under fixed or round-robin priority.
module ahbl_master_arbiter (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        ARB_MODE,
    input  logic [31:0] S0_HADDR,
    input  logic [1:0]  S0_HTRANS,
    input  logic        S0_HWRITE,
    input  logic [2:0]  S0_HSIZE,
    input  logic [31:0] S0_HWDATA,
    output logic [31:0] S0_HRDATA,
    output logic        S0_HREADY,
    output logic        S0_HRESP,
    input  logic [31:0] S1_HADDR,
    input  logic [1:0]  S1_HTRANS,
    input  logic        S1_HWRITE,
    input  logic [2:0]  S1_HSIZE,
    input  logic [31:0] S1_HWDATA,
    output logic [31:0] S1_HRDATA,
    output logic        S1_HREADY,
    output logic        S1_HRESP,
    output logic [31:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic        M_HWRITE,
    output logic [2:0]  M_HSIZE,
    output logic [31:0] M_HWDATA,
    input  logic [31:0] M_HRDATA,
    input  logic        M_HREADY,
    input  logic        M_HRESP,
    output logic        M_HMASTER
);

    logic [1:0]        pend_v_q, pend_v_d;
    logic [1:0][31:0]  pend_addr_q, pend_addr_d;
    logic [1:0]        pend_write_q, pend_write_d;
    logic [1:0][2:0]   pend_size_q, pend_size_d;
    logic [1:0]        out_q, out_d;
    logic              dp_v_q, dp_v_d;
    logic              dp_id_q, dp_id_d;
    logic              rr_last_q, rr_last_d;
    logic              hmaster_q, hmaster_d;

    logic [1:0]        req;
    logic [1:0]        cmp;
    logic [1:0]        s_ready;
    logic [1:0]        acc;
    logic              issue;
    logic              sel;
    logic              unused_htrans0;

    assign unused_htrans0 = S0_HTRANS[0] ^ S1_HTRANS[0];

    assign req = {S1_HTRANS[1], S0_HTRANS[1]};

    always_comb begin
        cmp[0]     = dp_v_q & (dp_id_q == 1'b0) & M_HREADY;
        cmp[1]     = dp_v_q & (dp_id_q == 1'b1) & M_HREADY;
        s_ready[0] = ~out_q[0] | cmp[0];
        s_ready[1] = ~out_q[1] | cmp[1];
        acc        = req & s_ready;
    end

    // A tie in round-robin mode goes to whichever port did not issue last.
    always_comb begin
        sel = 1'b0;
        unique case (1'b1)
            (pend_v_q == 2'b11): sel = ARB_MODE ? ~rr_last_q : 1'b0;
            (pend_v_q == 2'b10): sel = 1'b1;
            default:             sel = 1'b0;
        endcase
    end

    assign issue = M_HREADY & (|pend_v_q);

    always_comb begin
        M_HTRANS  = 2'b00;
        M_HADDR   = 32'h0;
        M_HWRITE  = 1'b0;
        M_HSIZE   = 3'b000;
        M_HMASTER = hmaster_q;
        if (issue) begin
            M_HTRANS  = 2'b10;
            M_HADDR   = pend_addr_q[sel];
            M_HWRITE  = pend_write_q[sel];
            M_HSIZE   = pend_size_q[sel];
            M_HMASTER = sel;
        end
    end

    always_comb begin
        M_HWDATA = 32'h0;
        if (dp_v_q) begin
            M_HWDATA = dp_id_q ? S1_HWDATA : S0_HWDATA;
        end
    end

    assign S0_HREADY = s_ready[0];
    assign S1_HREADY = s_ready[1];
    assign S0_HRESP  = dp_v_q & (dp_id_q == 1'b0) & M_HRESP;
    assign S1_HRESP  = dp_v_q & (dp_id_q == 1'b1) & M_HRESP;
    assign S0_HRDATA = M_HRDATA;
    assign S1_HRDATA = M_HRDATA;

    always_comb begin
        pend_v_d     = pend_v_q;
        pend_addr_d  = pend_addr_q;
        pend_write_d = pend_write_q;
        pend_size_d  = pend_size_q;
        out_d        = out_q;
        dp_v_d       = dp_v_q;
        dp_id_d      = dp_id_q;
        rr_last_d    = rr_last_q;
        hmaster_d    = hmaster_q;

        if (issue) begin
            pend_v_d[sel] = 1'b0;
            dp_v_d        = 1'b1;
            dp_id_d       = sel;
            rr_last_d     = sel;
            hmaster_d     = sel;
        end else if (M_HREADY) begin
            dp_v_d = 1'b0;
        end

        for (int m = 0; m < 2; m++) begin
            if (cmp[m]) begin
                out_d[m] = 1'b0;
            end
        end

        // An accept can only happen while the port has nothing pending,
        // so setting after the issue clear never loses a request.
        if (acc[0]) begin
            pend_v_d[0]     = 1'b1;
            pend_addr_d[0]  = S0_HADDR;
            pend_write_d[0] = S0_HWRITE;
            pend_size_d[0]  = S0_HSIZE;
            out_d[0]        = 1'b1;
        end
        if (acc[1]) begin
            pend_v_d[1]     = 1'b1;
            pend_addr_d[1]  = S1_HADDR;
            pend_write_d[1] = S1_HWRITE;
            pend_size_d[1]  = S1_HSIZE;
            out_d[1]        = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_v_q     <= 2'b00;
            pend_addr_q  <= '0;
            pend_write_q <= 2'b00;
            pend_size_q  <= '0;
            out_q        <= 2'b00;
            dp_v_q       <= 1'b0;
            dp_id_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            hmaster_q    <= 1'b0;
        end else begin
            pend_v_q     <= pend_v_d;
            pend_addr_q  <= pend_addr_d;
            pend_write_q <= pend_write_d;
            pend_size_q  <= pend_size_d;
            out_q        <= out_d;
            dp_v_q       <= dp_v_d;
            dp_id_q      <= dp_id_d;
            rr_last_q    <= rr_last_d;
            hmaster_q    <= hmaster_d;
        end
    end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter: arbitration, waits, ERROR,
// back-to-back gap fill and asynchronous reset mid-transfer.
module tb_ahbl_master_arbiter;

    logic        HCLK;
    logic        HRESETn;
    logic        ARB_MODE;
    logic [31:0] S0_HADDR, S1_HADDR;
    logic [1:0]  S0_HTRANS, S1_HTRANS;
    logic        S0_HWRITE, S1_HWRITE;
    logic [2:0]  S0_HSIZE, S1_HSIZE;
    logic [31:0] S0_HWDATA, S1_HWDATA;
    logic [31:0] S0_HRDATA, S1_HRDATA;
    logic        S0_HREADY, S1_HREADY;
    logic        S0_HRESP, S1_HRESP;
    logic [31:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE;
    logic [2:0]  M_HSIZE;
    logic [31:0] M_HWDATA;
    logic [31:0] M_HRDATA;
    logic        M_HREADY;
    logic        M_HRESP;
    logic        M_HMASTER;

    int checks = 0;
    int errors = 0;

    ahbl_master_arbiter dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .ARB_MODE  (ARB_MODE),
        .S0_HADDR  (S0_HADDR),
        .S0_HTRANS (S0_HTRANS),
        .S0_HWRITE (S0_HWRITE),
        .S0_HSIZE  (S0_HSIZE),
        .S0_HWDATA (S0_HWDATA),
        .S0_HRDATA (S0_HRDATA),
        .S0_HREADY (S0_HREADY),
        .S0_HRESP  (S0_HRESP),
        .S1_HADDR  (S1_HADDR),
        .S1_HTRANS (S1_HTRANS),
        .S1_HWRITE (S1_HWRITE),
        .S1_HSIZE  (S1_HSIZE),
        .S1_HWDATA (S1_HWDATA),
        .S1_HRDATA (S1_HRDATA),
        .S1_HREADY (S1_HREADY),
        .S1_HRESP  (S1_HRESP),
        .M_HADDR   (M_HADDR),
        .M_HTRANS  (M_HTRANS),
        .M_HWRITE  (M_HWRITE),
        .M_HSIZE   (M_HSIZE),
        .M_HWDATA  (M_HWDATA),
        .M_HRDATA  (M_HRDATA),
        .M_HREADY  (M_HREADY),
        .M_HRESP   (M_HRESP),
        .M_HMASTER (M_HMASTER)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESETn   = 1'b0;
        ARB_MODE  = 1'b0;
        S0_HADDR  = '0; S0_HTRANS = '0; S0_HWRITE = 1'b0;
        S0_HSIZE  = 3'd2; S0_HWDATA = '0;
        S1_HADDR  = '0; S1_HTRANS = '0; S1_HWRITE = 1'b0;
        S1_HSIZE  = 3'd2; S1_HWDATA = '0;
        M_HRDATA  = '0; M_HREADY = 1'b1; M_HRESP = 1'b0;
        #3;
        chk("rst_htrans", M_HTRANS, 0);
        chk("rst_haddr", M_HADDR, 0);
        chk("rst_hwrite", M_HWRITE, 0);
        chk("rst_hsize", M_HSIZE, 0);
        chk("rst_hwdata", M_HWDATA, 0);
        chk("rst_hmaster", M_HMASTER, 0);
        chk("rst_s0_ready", S0_HREADY, 1);
        chk("rst_s1_ready", S1_HREADY, 1);
        chk("rst_s0_resp", S0_HRESP, 0);
        chk("rst_s1_resp", S1_HRESP, 0);
        step();
        step();
        HRESETn = 1'b1;

        // Round-robin tie right after reset: S0 first.
        step();
        ARB_MODE = 1'b1;
        S0_HTRANS = 2'b10; S0_HADDR = 32'h0000_0100;
        S1_HTRANS = 2'b10; S1_HADDR = 32'h0000_0200;
        #1;
        chk("rr1_acc_s0", S0_HREADY, 1);
        chk("rr1_acc_s1", S1_HREADY, 1);
        chk("rr1_idle", M_HTRANS, 0);
        step();
        S0_HTRANS = 2'b00; S1_HTRANS = 2'b00;
        #1;
        chk("rr1_a_trans", M_HTRANS, 2);
        chk("rr1_a_addr", M_HADDR, 32'h0000_0100);
        chk("rr1_a_master", M_HMASTER, 0);
        chk("rr1_a_s0_wait", S0_HREADY, 0);
        step();
        #1;
        chk("rr1_b_s0_done", S0_HREADY, 1);
        chk("rr1_b_addr", M_HADDR, 32'h0000_0200);
        chk("rr1_b_master", M_HMASTER, 1);
        chk("rr1_b_s1_wait", S1_HREADY, 0);
        step();
        #1;
        chk("rr1_c_s1_done", S1_HREADY, 1);
        chk("rr1_c_idle", M_HTRANS, 0);
        chk("rr1_c_master", M_HMASTER, 1);

        // S0 single read.
        step();
        S0_HTRANS = 2'b10; S0_HADDR = 32'h2000_0010;
        #1;
        step();
        S0_HTRANS = 2'b00;
        #1;
        chk("rd_trans", M_HTRANS, 2);
        chk("rd_addr", M_HADDR, 32'h2000_0010);
        chk("rd_write", M_HWRITE, 0);
        chk("rd_size", M_HSIZE, 2);
        chk("rd_s0_wait", S0_HREADY, 0);
        step();
        M_HRDATA = 32'h0000_A5A5;
        #1;
        chk("rd_s0_ready", S0_HREADY, 1);
        chk("rd_s0_rdata", S0_HRDATA, 32'h0000_A5A5);
        chk("rd_idle", M_HTRANS, 0);
        step();
        M_HRDATA = '0;
        #1;
        chk("rd_after_ready", S0_HREADY, 1);
        chk("rd_after_wdata", M_HWDATA, 0);

        // Second tie: S0 issued last, so S1 goes first.
        step();
        S0_HTRANS = 2'b10; S0_HADDR = 32'h0000_0300;
        S1_HTRANS = 2'b10; S1_HADDR = 32'h0000_0400;
        #1;
        step();
        S0_HTRANS = 2'b00; S1_HTRANS = 2'b00;
        #1;
        chk("rr2_a_addr", M_HADDR, 32'h0000_0400);
        chk("rr2_a_master", M_HMASTER, 1);
        step();
        #1;
        chk("rr2_b_addr", M_HADDR, 32'h0000_0300);
        chk("rr2_b_master", M_HMASTER, 0);
        chk("rr2_b_s1_done", S1_HREADY, 1);
        step();
        #1;
        chk("rr2_c_s0_done", S0_HREADY, 1);
        chk("rr2_c_idle", M_HTRANS, 0);

        // Fixed priority: S1 fills S0's back-to-back gap.
        step();
        ARB_MODE = 1'b0;
        S0_HTRANS = 2'b10; S0_HADDR = 32'h0000_0500;
        S1_HTRANS = 2'b10; S1_HADDR = 32'h0000_0600;
        #1;
        step();
        S1_HTRANS = 2'b00;
        #1;
        chk("gap_a_addr", M_HADDR, 32'h0000_0500);
        chk("gap_a_master", M_HMASTER, 0);
        step();
        #1;
        chk("gap_b_addr", M_HADDR, 32'h0000_0600);
        chk("gap_b_master", M_HMASTER, 1);
        chk("gap_b_s0_done", S0_HREADY, 1);
        step();
        #1;
        chk("gap_c_addr", M_HADDR, 32'h0000_0500);
        chk("gap_c_master", M_HMASTER, 0);
        chk("gap_c_s1_done", S1_HREADY, 1);
        chk("gap_c_s0_wait", S0_HREADY, 0);
        step();
        S0_HTRANS = 2'b00;
        #1;
        chk("gap_d_s0_done", S0_HREADY, 1);
        chk("gap_d_idle", M_HTRANS, 0);
        step();
        #1;
        chk("gap_e_idle", M_HTRANS, 0);

        // S1 write with three wait states while S0 is pending.
        step();
        S1_HTRANS = 2'b10; S1_HADDR = 32'h4000_0000; S1_HWRITE = 1'b1;
        #1;
        step();
        S1_HTRANS = 2'b00; S1_HWRITE = 1'b0; S1_HWDATA = 32'hDEAD_BEEF;
        S0_HTRANS = 2'b10; S0_HADDR = 32'h0000_0700;
        #1;
        chk("wr_addr", M_HADDR, 32'h4000_0000);
        chk("wr_write", M_HWRITE, 1);
        chk("wr_master", M_HMASTER, 1);
        chk("wr_s0_acc", S0_HREADY, 1);
        step();
        S0_HTRANS = 2'b00; M_HREADY = 1'b0;
        #1;
        chk("wr_w1_wdata", M_HWDATA, 32'hDEAD_BEEF);
        chk("wr_w1_trans", M_HTRANS, 0);
        chk("wr_w1_s1_wait", S1_HREADY, 0);
        step();
        #1;
        chk("wr_w2_wdata", M_HWDATA, 32'hDEAD_BEEF);
        chk("wr_w2_trans", M_HTRANS, 0);
        step();
        #1;
        chk("wr_w3_wdata", M_HWDATA, 32'hDEAD_BEEF);
        chk("wr_w3_trans", M_HTRANS, 0);
        chk("wr_w3_addr", M_HADDR, 0);
        step();
        M_HREADY = 1'b1;
        #1;
        chk("wr_last_wdata", M_HWDATA, 32'hDEAD_BEEF);
        chk("wr_last_trans", M_HTRANS, 2);
        chk("wr_last_addr", M_HADDR, 32'h0000_0700);
        chk("wr_last_s1_done", S1_HREADY, 1);
        step();
        S1_HWDATA = '0;
        #1;
        chk("wr_s0_done", S0_HREADY, 1);
        chk("wr_s0_master", M_HMASTER, 0);
        chk("wr_s0_wdata", M_HWDATA, 0);
        step();
        #1;
        chk("wr_idle", M_HTRANS, 0);

        // Two-cycle ERROR on an S1 read.
        step();
        S1_HTRANS = 2'b10; S1_HADDR = 32'h0000_0800;
        #1;
        step();
        S1_HTRANS = 2'b00;
        #1;
        chk("err_master", M_HMASTER, 1);
        chk("err_addr", M_HADDR, 32'h0000_0800);
        step();
        M_HRESP = 1'b1; M_HREADY = 1'b0;
        #1;
        chk("err1_s1_resp", S1_HRESP, 1);
        chk("err1_s1_ready", S1_HREADY, 0);
        chk("err1_s0_resp", S0_HRESP, 0);
        step();
        M_HREADY = 1'b1;
        #1;
        chk("err2_s1_resp", S1_HRESP, 1);
        chk("err2_s1_ready", S1_HREADY, 1);
        chk("err2_s0_resp", S0_HRESP, 0);
        step();
        M_HRESP = 1'b0;
        #1;
        chk("err3_s1_resp", S1_HRESP, 0);
        chk("err3_s1_ready", S1_HREADY, 1);

        // Reset during an S0 data phase with S1 pending.
        step();
        S0_HTRANS = 2'b10; S0_HADDR = 32'h0000_0900;
        S1_HTRANS = 2'b10; S1_HADDR = 32'h0000_0A00;
        #1;
        step();
        S0_HTRANS = 2'b00; S1_HTRANS = 2'b00; S0_HWDATA = 32'h1111_2222;
        #1;
        chk("rst_mid_addr", M_HADDR, 32'h0000_0900);
        step();
        M_HREADY = 1'b0;
        #1;
        chk("rst_mid_wdata", M_HWDATA, 32'h1111_2222);
        chk("rst_mid_s0_wait", S0_HREADY, 0);
        chk("rst_mid_s1_wait", S1_HREADY, 0);
        HRESETn = 1'b0;
        #1;
        chk("rst_async_wdata", M_HWDATA, 0);
        chk("rst_async_trans", M_HTRANS, 0);
        chk("rst_async_s0", S0_HREADY, 1);
        chk("rst_async_s1", S1_HREADY, 1);
        chk("rst_async_master", M_HMASTER, 0);
        M_HREADY = 1'b1;
        #1;
        chk("rst_hold_trans", M_HTRANS, 0);
        step();
        HRESETn = 1'b1; S0_HWDATA = '0;
        #1;
        chk("rst_rel_trans", M_HTRANS, 0);
        step();
        #1;
        chk("rst_rel2_trans", M_HTRANS, 0);
        chk("rst_rel2_addr", M_HADDR, 0);
        step();
        S1_HTRANS = 2'b10; S1_HADDR = 32'h0000_0B00;
        #1;
        step();
        S1_HTRANS = 2'b00;
        #1;
        chk("rst_new_trans", M_HTRANS, 2);
        chk("rst_new_addr", M_HADDR, 32'h0000_0B00);
        step();
        #1;
        chk("rst_new_done", S1_HREADY, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
